// File: rtl/cordic_trig_iter.sv
// Iterative CORDIC: float32 radians in, cos/sin in signed Q2.30 out, one micro-rotation per clock.
// Latency: done asserts ITER+1 rising edges after the accepting edge; back-to-back issue every ITER+1 cycles.
// Backpressure: start is taken only while busy=0 (IDLE or FIN); start during rotation is dropped.
//
// Ports: clk/rst_n (async active-low); start/angle request; busy, done (1-cycle pulse), err (with done);
//        cos_out/sin_out results; theta = residual angle after the last micro-rotation (debug).
module cordic_trig_iter #(
    parameter int ITER  = 16,
    parameter int WIDTH = 32,
    parameter int FRAC  = 30
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      angle,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] cos_out,
    output logic [WIDTH-1:0] sin_out,
    output logic [WIDTH-1:0] theta
);

    typedef enum logic [1:0] {S_IDLE, S_ROT, S_FIN} state_t;

    // round(atan(2^-i) * 2^30); beyond i=9 the cubic term is below half an LSB.
    function automatic logic [WIDTH-1:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lut = WIDTH'(32'h3243F6A8);
            5'd1:    atan_lut = WIDTH'(32'h1DAC6705);
            5'd2:    atan_lut = WIDTH'(32'h0FADBAFD);
            5'd3:    atan_lut = WIDTH'(32'h07F56EA7);
            5'd4:    atan_lut = WIDTH'(32'h03FEAB77);
            5'd5:    atan_lut = WIDTH'(32'h01FFD55C);
            5'd6:    atan_lut = WIDTH'(32'h00FFFAAB);
            5'd7:    atan_lut = WIDTH'(32'h007FFF55);
            5'd8:    atan_lut = WIDTH'(32'h003FFFEB);
            5'd9:    atan_lut = WIDTH'(32'h001FFFFD);
            default: atan_lut = WIDTH'(1) << (5'd30 - idx);
        endcase
    endfunction

    // Pre-scaled start vector: product of 1/sqrt(1+2^-2i) over the iterations actually run.
    function automatic logic [WIDTH-1:0] k_const(input int n);
        case (n)
            8:       k_const = WIDTH'(32'd652039507);
            9:       k_const = WIDTH'(32'd652034532);
            10:      k_const = WIDTH'(32'd652033289);
            11:      k_const = WIDTH'(32'd652032978);
            12:      k_const = WIDTH'(32'd652032900);
            13:      k_const = WIDTH'(32'd652032881);
            14:      k_const = WIDTH'(32'd652032876);
            15:      k_const = WIDTH'(32'd652032874);
            default: k_const = WIDTH'(32'h26DD3B6A);
        endcase
    endfunction

    localparam logic [WIDTH-1:0] K_INIT  = k_const(ITER);
    localparam logic [4:0]       I_LAST  = 5'(ITER - 1);
    // Exponent bounds: below E_LO the angle is under one LSB; E_PIVOT is the unshifted point.
    localparam logic [7:0]       E_LO    = 8'(127 - FRAC);
    localparam logic [7:0]       E_PIVOT = 8'(150 - FRAC);

    state_t                  state_q, state_d;
    logic [4:0]              i_q, i_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic                    err_pend_q, err_pend_d;
    logic                    err_q, err_d;
    logic [WIDTH-1:0]        cos_q, cos_d, sin_q, sin_d, theta_q, theta_d;

    // float32 -> Q2.30, truncated toward zero
    logic [7:0]       ang_exp;
    logic [23:0]      ang_man;
    logic [WIDTH-1:0] conv_mag, conv_z;
    logic             conv_err;

    assign ang_exp = angle[30:23];
    assign ang_man = {1'b1, angle[22:0]};

    always_comb begin
        conv_err = 1'b0;
        conv_mag = '0;
        if (ang_exp >= 8'd128) begin
            conv_err = 1'b1;                 // |a| >= 2, inf, NaN
        end else if (ang_exp >= E_LO) begin
            if (ang_exp >= E_PIVOT) conv_mag = WIDTH'(ang_man) << (ang_exp - E_PIVOT);
            else                    conv_mag = WIDTH'(ang_man) >> (E_PIVOT - ang_exp);
        end
    end

    assign conv_z = angle[31] ? -conv_mag : conv_mag;

    // One micro-rotation; direction from sign of z (z>=0 rotates positive).
    logic signed [WIDTH-1:0] x_sh, y_sh, atan_i, x_rot, y_rot, z_rot;
    logic                    d_neg;

    assign x_sh   = x_q >>> i_q;
    assign y_sh   = y_q >>> i_q;
    assign atan_i = atan_lut(i_q);
    assign d_neg  = z_q[WIDTH-1];
    assign x_rot  = d_neg ? x_q + y_sh   : x_q - y_sh;
    assign y_rot  = d_neg ? y_q - x_sh   : y_q + x_sh;
    assign z_rot  = d_neg ? z_q + atan_i : z_q - atan_i;

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        err_pend_d = err_pend_q;
        err_d      = err_q;
        cos_d      = cos_q;
        sin_d      = sin_q;
        theta_d    = theta_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    state_d    = S_ROT;
                    i_d        = '0;
                    x_d        = K_INIT;
                    y_d        = '0;
                    z_d        = conv_z;
                    err_pend_d = conv_err;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROT: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                if (i_q == I_LAST) begin
                    // Results land on the edge into FIN so they are valid alongside done.
                    state_d = S_FIN;
                    cos_d   = x_rot;
                    sin_d   = y_rot;
                    theta_d = z_rot;
                    err_d   = err_pend_q;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
            cos_q      <= '0;
            sin_q      <= '0;
            theta_q    <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
            cos_q      <= cos_d;
            sin_q      <= sin_d;
            theta_q    <= theta_d;
        end
    end

    assign busy    = (state_q == S_ROT);
    assign done    = (state_q == S_FIN);
    assign err     = err_q;
    assign cos_out = cos_q;
    assign sin_out = sin_q;
    assign theta   = theta_q;

endmodule

// File: tb/tb_cordic_trig_iter.sv
module tb_cordic_trig_iter;

    localparam int ITER = 16;
    localparam longint TOL = 64'h10000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] angle = '0;
    logic        busy, done, err;
    logic [31:0] cos_out, sin_out, theta;

    int checks = 0;
    int errors = 0;
    real rng;      // largest angle the 16-step rotation can reach

    cordic_trig_iter #(.ITER(ITER), .WIDTH(32), .FRAC(30)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .angle(angle),
        .busy(busy), .done(done), .err(err),
        .cos_out(cos_out), .sin_out(sin_out), .theta(theta)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ang;
        logic [31:0] cos_e;
        logic [31:0] sin_e;
        logic        err_e;
    } vec_t;

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input logic [31:0] act, input longint exp);
        longint diff;
        checks++;
        diff = longint'($signed(act)) - exp;
        if (diff < 0) diff = -diff;
        if (diff > TOL) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h +/- 0x%0h", name, act, exp[31:0], TOL);
        end
    endtask

    // Reference: decode the float with real math, truncate to Q30, limit to the
    // reachable rotation range, then take true cos/sin.
    task automatic model(input logic [31:0] a, output longint ec, output longint es,
                         output logic ee, output bit inr);
        int  e;
        real mag, ang;
        e   = int'(a[30:23]);
        ee  = 1'b0;
        inr = 1'b1;
        ang = 0.0;
        if (e >= 128) begin
            ee = 1'b1;
        end else if (e >= 97) begin
            mag = $floor(real'({1'b1, a[22:0]}) * (2.0 ** (e - 120)));
            ang = mag / (2.0 ** 30);
            if (a[31]) ang = -ang;
        end
        if (ang > rng)  begin ang = rng;  inr = 1'b0; end
        if (ang < -rng) begin ang = -rng; inr = 1'b0; end
        ec = longint'($rtoi($floor($cos(ang) * (2.0 ** 30) + 0.5)));
        es = longint'($rtoi($floor($sin(ang) * (2.0 ** 30) + 0.5)));
    endtask

    // Issue one request and wait (bounded) for done. With now=1 the caller is
    // already at the sampling point of a FIN cycle and start is raised there.
    task automatic run_op(input logic [31:0] a, input bit now, output int lat, output bit got,
                          output logic [31:0] c, output logic [31:0] s, output logic [31:0] t,
                          output logic e);
        int k;
        if (!now) @(negedge clk);
        start = 1'b1;
        angle = a;
        @(posedge clk);
        lat = 1;
        got = 1'b0;
        c = '0; s = '0; t = '0; e = 1'b0;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!got && k < 60) begin
            if (done) begin
                got = 1'b1;
                c = cos_out; s = sin_out; t = theta; e = err;
            end else begin
                @(posedge clk);
                lat++;
                @(negedge clk);
                k++;
            end
        end
    endtask

    vec_t        vecs[6];
    int          lat;
    bit          got, inr;
    logic [31:0] c, s, t;
    logic        e;
    longint      ec, es;
    logic        ee;
    int          ndone;
    logic [31:0] a;

    initial begin
        rng = 0.0;
        for (int i = 0; i < ITER; i++) rng += $atan(2.0 ** (-i));

        vecs[0] = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[1] = '{32'h3F800000, 32'h2294501F, 32'h35DAA91E, 1'b0};
        vecs[2] = '{32'hBF800000, 32'h2294501F, 32'hCA2556E2, 1'b0};
        vecs[3] = '{32'h40000000, 32'h40000000, 32'h00000000, 1'b1};
        vecs[4] = '{32'h7FC00000, 32'h40000000, 32'h00000000, 1'b1};
        vecs[5] = '{32'h30800000, 32'h40000000, 32'h00000000, 1'b0};

        // Reset state
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err",  err,  0);
        check_eq("rst_cos",  cos_out, 0);
        check_eq("rst_sin",  sin_out, 0);
        check_eq("rst_theta", theta, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].ang, 1'b0, lat, got, c, s, t, e);
            check_eq($sformatf("vec%0d_done", v), got, 1);
            check_eq($sformatf("vec%0d_latency", v), lat, ITER + 1);
            check_eq($sformatf("vec%0d_err", v), e, vecs[v].err_e);
            check_tol($sformatf("vec%0d_cos", v), c, longint'($signed(vecs[v].cos_e)));
            check_tol($sformatf("vec%0d_sin", v), s, longint'($signed(vecs[v].sin_e)));
        end

        // 1.75 rad: beyond convergence range, no error, unconverged residual
        run_op(32'h3FE00000, 1'b0, lat, got, c, s, t, e);
        model(32'h3FE00000, ec, es, ee, inr);
        check_eq("a175_done", got, 1);
        check_eq("a175_err", e, 0);
        check_tol("a175_cos", c, ec);
        check_tol("a175_sin", s, es);
        checks++;
        if (t == 32'h0) begin
            errors++;
            $display("FAIL a175_theta: got 0x%08h, expected nonzero", t);
        end

        // Random angles against the reference model
        for (int r = 0; r < 30; r++) begin
            int ex;
            ex = int'($urandom_range(95, 130));
            a = {1'($urandom_range(0, 1)), 8'(ex), 23'($urandom)};
            if (r == 0) a = 32'h00012345;          // denormal
            if (r == 1) a = 32'hFF800000;          // -inf
            model(a, ec, es, ee, inr);
            run_op(a, 1'b0, lat, got, c, s, t, e);
            check_eq($sformatf("rnd%0d_done a=%08h", r, a), got, 1);
            check_eq($sformatf("rnd%0d_err a=%08h", r, a), e, ee);
            check_tol($sformatf("rnd%0d_cos a=%08h", r, a), c, ec);
            check_tol($sformatf("rnd%0d_sin a=%08h", r, a), s, es);
            if (inr && !ee) begin
                checks++;
                if ($signed(t) > 32'sh10000 || $signed(t) < -32'sh10000) begin
                    errors++;
                    $display("FAIL rnd%0d_theta a=%08h: got 0x%08h, expected |theta| <= 0x10000", r, a, t);
                end
            end
        end

        // Start pulsed during rotation is ignored
        @(negedge clk);
        start = 1'b1; angle = 32'h3F800000;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; angle = 32'h00000000;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        c = '0; s = '0;
        for (int k = 0; k < 60; k++) begin
            if (done) begin ndone++; c = cos_out; s = sin_out; end
            @(negedge clk);
        end
        check_eq("ign_done_count", ndone, 1);
        check_tol("ign_cos", c, 64'sh2294501F);
        check_tol("ign_sin", s, 64'sh35DAA91E);

        // Back-to-back: second start raised in the FIN cycle
        run_op(32'h3F000000, 1'b0, lat, got, c, s, t, e);
        check_eq("b2b_first_done", got, 1);
        run_op(32'hBF800000, 1'b1, lat, got, c, s, t, e);
        model(32'hBF800000, ec, es, ee, inr);
        check_eq("b2b_second_done", got, 1);
        check_eq("b2b_period", lat, ITER + 1);
        check_tol("b2b_cos", c, ec);
        check_tol("b2b_sin", s, es);

        // Reset mid-rotation after an erroring op left nonzero outputs
        run_op(32'h7FC00000, 1'b0, lat, got, c, s, t, e);
        check_eq("pre_rst_err", e, 1);
        @(negedge clk);
        start = 1'b1; angle = 32'h3F800000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check_eq("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_err", err, 0);
        check_eq("mid_rst_cos", cos_out, 0);
        check_eq("mid_rst_sin", sin_out, 0);
        check_eq("mid_rst_theta", theta, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_eq("post_rst_no_done", ndone, 0);
        run_op(32'h3F800000, 1'b0, lat, got, c, s, t, e);
        check_eq("post_rst_done", got, 1);
        check_eq("post_rst_latency", lat, ITER + 1);
        check_tol("post_rst_cos", c, 64'sh2294501F);
        check_tol("post_rst_sin", s, 64'sh35DAA91E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_trig_iter.md
Name: cordic_trig_iter

Overview:
- Sequential, parametrised successor to the combinational cosine CORDIC.
- Accepts an IEEE-754 single-precision angle in radians and converts it to signed Q2.30 fixed point.
- Runs one CORDIC micro-rotation per clock, then returns both cos and sin in signed Q2.30.
- Sits behind the processor custom-instruction/accelerator interface and trades latency for area.

Parameters:
- ITER, 16, number of micro-rotations; legal range 8..30.
- WIDTH, 32, datapath width of x/y/z; fixed by the Q2.30 format.
- FRAC, 30, fractional bits of all fixed-point values.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- angle  in  32  float32 angle in radians.
- busy  out  1  high while rotating.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- err  out  1  angle invalid; valid with done.
- cos_out  out  32  cos(angle), signed Q2.30.
- sin_out  out  32  sin(angle), signed Q2.30.
- theta  out  32  residual z after the last iteration, signed Q2.30, for debug.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, err=0.
  - cos_out, sin_out and theta are all 0.
  - Iteration counter is 0.
  - Reset mid-rotation aborts the operation with no done pulse.
- States:
  - IDLE -> ROT when start=1.
  - ROT -> ROT while i<ITER-1.
  - ROT -> FIN when i=ITER-1.
  - FIN -> IDLE, or -> ROT if start=1 in the FIN cycle.
- Start handshake:
  - start is accepted in IDLE or FIN (busy=0).
  - On the accepting edge, load z=conv(angle), x=K(ITER), y=0, i=0, and set busy=1.
  - start while busy=1 is ignored and does not affect the current operation.
- Rotation (one per cycle in ROT):
  - d = sign(z), with z>=0 treated as +.
  - x' = x - d*(y>>>i)
  - y' = y + d*(x>>>i)
  - z' = z - d*atan_tab[i]
  - Shifts are arithmetic; add/sub is WIDTH-bit two's complement with no saturation.
- FIN (exactly one cycle):
  - done=1, busy=0.
  - cos_out=x, sin_out=y, theta=z are registered here.
  - Outputs hold until the next FIN or reset.
- Latency: done is high in the cycle after the (ITER+1)th rising edge counted from the accepting edge. For ITER=16 that is 17 edges.
- Back-to-back: start in the FIN cycle gives one result every ITER+1 cycles.
- atan_tab[i] = round(atan(2^-i)·2^30), i=0..29; atan_tab[0]=0x3243F6A8.
- K(ITER) = Q30 of Π 1/√(1+2^-2i); K=0x26DD3B6A for ITER≥16. Shorter ITER values use a per-ITER constant table.
- Float conversion, with e=angle[30:23], m={1,angle[22:0]}:
  - e=0 (zero/denormal), or e<97 (|a|<2^-30): result 0, err=0.
  - 97≤e≤127: |z| = m shifted by (e-120), truncated toward zero; sign applied from angle[31].
  - e≥128 (|a|≥2, includes inf/NaN): err=1, z=0. Rotation still runs, so cos≈1, sin≈0.
- Convergence: 1.7433<|a|<2 is processed without error. The result is the rotation by ±1.7433 rad, and theta reports the unconverged residual.
- err is captured at start acceptance and presented unchanged until the next done.

Test Plan:
- Angle 0x00000000, ITER=16 -> done after 17 edges; cos_out 0x40000000 ±0x10000, sin_out 0 ±0x10000, err=0.
- Angle 0x3F800000 (1.0) -> cos_out 0x2294501F ±0x10000, sin_out 0x35DAA91E ±0x10000.
- Angle 0xBF800000 (-1.0) -> cos_out 0x2294501F, sin_out 0xCA2556E2, both ±0x10000.
- Angle 0x40000000 (2.0), then 0x7FC00000 (NaN) -> err=1 with done both times; cos≈0x40000000. Angle 0x30800000 (2^-30) -> z load 0x00000001, err=0.
- Start pulsed during ROT -> ignored, single done. Start during FIN -> second result exactly 17 cycles later. Angle 0x3FE00000 (1.75) -> no err, theta ≠ 0.
- Deassert rst_n at iteration 5 -> busy, done, err and outputs go to 0 immediately and no done follows. A fresh start then completes normally.
